serial_subtractor: RTL and testbench
====================================

# serial_subtractor

Bit-serial unsigned subtractor. It computes `a - b - bin` over `WIDTH` clock cycles, one bit per cycle, LSB first. Each cycle applies the single-bit full-subtractor equations and registers the borrow between cycles. It sits directly upstream of the word-level consumers of the subtractor path and reuses the 1-bit full-subtractor cell as its per-cycle datapath. The block trades latency for area and signals completion with a start/done handshake.

## Interface
- `WIDTH`, default 8: operand and result width in bits; legal range 1..32.

- `clk`  input  1  clock; all state changes on its rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `start`  input  1  request; sampled only in IDLE.
- `a`  input  WIDTH  minuend; captured on the accepting edge.
- `b`  input  WIDTH  subtrahend; captured on the accepting edge.
- `bin`  input  1  borrow-in; captured on the accepting edge.
- `busy`  output  1  high while in RUN.
- `done`  output  1  one-cycle pulse in DONE; `diff` and `bout` are valid.
- `diff`  output  WIDTH  registered result `(a - b - bin) mod 2^WIDTH`.
- `bout`  output  1  registered final borrow; 1 iff `a < b + bin` (unsigned).

## Operation
- States:
  - IDLE → RUN on `start=1`.
  - RUN → DONE after `WIDTH` bit-cycles.
  - DONE → IDLE unconditionally, after one cycle.
- Accept, IDLE with `start=1`:
  - Load shift registers `a_sh←a`, `b_sh←b`.
  - Load `brw←bin` and `cnt←0`.
  - Clear the internal result shift register.
- RUN, per cycle, with `x=a_sh[0]`, `y=b_sh[0]`:
  - `d = x^y^brw`.
  - `brw ← (~x&y) | (~(x^y)&brw)`.
  - Shift `a_sh` and `b_sh` right by 1.
  - Shift `d` into the result register at the MSB end; after `WIDTH` shifts, bit i of the result holds result bit i.
  - `cnt` increments.
  - When `cnt == WIDTH-1`, the transition is to DONE.
- Entering DONE:
  - `diff` ← completed result, including the final bit.
  - `bout` ← final borrow.
- Output holding:
  - `diff` and `bout` change only on entry to DONE or on reset.
  - They hold their values through IDLE until the next result completes.
  - Partial results are never visible on `diff`.
- `start` during RUN or DONE is ignored: no queuing, no restart.
- Inputs `a`, `b` and `bin` are don't-care except on the accepting edge.
- `WIDTH=1`:
  - RUN lasts exactly one cycle.
  - The block reduces to a registered full subtractor.
- `cnt` width is `$clog2(WIDTH+1)`. `cnt` never wraps, because exit happens at `WIDTH-1`.

## Timing
- Reset:
  - Asserting `rst` at any time, including mid-RUN, immediately forces state to IDLE.
  - It clears `busy=0`, `done=0`, `diff=0`, `bout=0`, and clears all internal registers.
  - An in-flight operation is discarded.
  - The first accept can occur on the first rising edge after `rst` deasserts.
- Let edge k be the edge that accepts `start`:
  - `busy=1` from after edge k through edge k+WIDTH.
  - Bits 0..WIDTH-1 are computed on edges k+1..k+WIDTH.
  - After edge k+WIDTH: state is DONE, `done=1`, `busy=0`, and `diff`/`bout` are valid.
  - After edge k+WIDTH+1: state is IDLE, `done=0`.
  - The next `start` is accepted at edge k+WIDTH+2 at the earliest.
- Latency from accepting edge to `done` is WIDTH edges. Throughput is one operation per WIDTH+2 cycles.
- `busy` and `done` are never high together.

## Test plan
- Reset: assert `rst` mid-cycle with no clock → `busy=0`, `done=0`, `diff=0`, `bout=0` immediately.
- WIDTH=8, `a=8'h5A`, `b=8'h23`, `bin=0` →
  - `done` is high exactly 8 edges after the accepting edge.
  - `diff=8'h37`, `bout=0`.
  - `busy` is high for 8 cycles.
- Underflow, WIDTH=8:
  - `a=8'h00`, `b=8'h01`, `bin=0` → `diff=8'hFF`, `bout=1`.
  - `a=8'h10`, `b=8'h10`, `bin=1` → `diff=8'hFF`, `bout=1`.
  - `a=8'h80`, `b=8'h7F`, `bin=1` → `diff=8'h00`, `bout=0`.
- Start during busy and mid-run reset:
  - Pulse `start` with new operands at RUN cycle 3 → ignored; the original result is correct.
  - Next, assert `rst` at RUN cycle 4 → all outputs 0, state IDLE.
  - A fresh `start` then completes correctly.
- Back-to-back and hold:
  - Hold `start=1` continuously → operations complete every 10 cycles.
  - `diff` is stable between `done` pulses.
  - `diff` never shows partial values.
- WIDTH=1, all 8 combinations of `a`, `b`, `bin` → `diff`/`bout` match the full-subtractor truth table. Example: a=0, b=1, bin=1 → diff=0, bout=1.

Source files
------------

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: computes a - b - bin LSB first, one bit per clock,
// with a start/done handshake and results held until the next operation completes.
module serial_subtractor #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             bin_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] diff_o,
  output logic             bout_o
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_sh_q, b_sh_q, res_q, diff_q;
  logic [WIDTH-1:0] res_d;
  logic [CntW-1:0]  cnt_q;
  logic             brw_q, brw_d, bout_q, busy_q, done_q;
  logic             x, y, d, last_bit;

  // Single-bit full-subtractor cell on the current operand LSBs.
  always_comb begin
    x        = a_sh_q[0];
    y        = b_sh_q[0];
    d        = x ^ y ^ brw_q;
    brw_d    = (~x & y) | (~(x ^ y) & brw_q);
    last_bit = (cnt_q == CntW'(WIDTH - 1));
  end

  // Result bits enter at the MSB end so bit i lands in place after WIDTH shifts.
  if (WIDTH == 1) begin : g_res_w1
    assign res_d = d;
  end else begin : g_res_wn
    assign res_d = {d, res_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      brw_q   <= 1'b0;
      bout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          done_q <= 1'b0;
          if (start_i) begin
            a_sh_q  <= a_i;
            b_sh_q  <= b_i;
            brw_q   <= bin_i;
            cnt_q   <= '0;
            res_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= StRun;
          end
        end
        StRun: begin
          a_sh_q <= a_sh_q >> 1;
          b_sh_q <= b_sh_q >> 1;
          res_q  <= res_d;
          brw_q  <= brw_d;
          cnt_q  <= cnt_q + CntW'(1);
          if (last_bit) begin
            diff_q  <= res_d;
            bout_q  <= brw_d;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= StDone;
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign busy_o = busy_q;
  assign done_o = done_q;
  assign diff_o = diff_q;
  assign bout_o = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor at WIDTH=8 and WIDTH=1 with an expected-result queue.
module tb_serial_subtractor;

  logic       clk, rst;
  logic       start8, start1;
  logic [7:0] a8, b8;
  logic       bin8;
  logic [0:0] a1, b1;
  logic       bin1;
  logic       busy8, done8, bout8;
  logic [7:0] diff8;
  logic       busy1, done1, bout1;
  logic [0:0] diff1;

  logic       sel1;
  logic       obs_busy, obs_done, obs_bout;
  logic [7:0] obs_diff;

  int         n_vec = 0;
  int         n_err = 0;
  logic [7:0] qd[$];
  logic       qb[$];

  serial_subtractor #(.WIDTH(8)) dut8 (
    .clk_i(clk), .rst_i(rst), .start_i(start8), .a_i(a8), .b_i(b8), .bin_i(bin8),
    .busy_o(busy8), .done_o(done8), .diff_o(diff8), .bout_o(bout8)
  );

  serial_subtractor #(.WIDTH(1)) dut1 (
    .clk_i(clk), .rst_i(rst), .start_i(start1), .a_i(a1), .b_i(b1), .bin_i(bin1),
    .busy_o(busy1), .done_o(done1), .diff_o(diff1), .bout_o(bout1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    obs_busy = sel1 ? busy1 : busy8;
    obs_done = sel1 ? done1 : done8;
    obs_bout = sel1 ? bout1 : bout8;
    obs_diff = sel1 ? {7'b0, diff1} : diff8;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: plain word-level subtraction, bit 8 is the borrow out.
  function automatic logic [8:0] model(input logic [7:0] a, input logic [7:0] b, input logic bi);
    return {1'b0, a} - {1'b0, b} - {8'b0, bi};
  endfunction

  task automatic push_exp(input logic w1, input logic [7:0] a, input logic [7:0] b,
                          input logic bi);
    logic [8:0] f;
    f = w1 ? model({7'b0, a[0]}, {7'b0, b[0]}, bi) : model(a, b, bi);
    qd.push_back(w1 ? {7'b0, f[0]} : f[7:0]);
    qb.push_back(f[8]);
  endtask

  task automatic run_op(input logic w1, input logic [7:0] a, input logic [7:0] b,
                        input logic bi, input int poke, input string tag);
    int lat, busy_n, w;
    w = w1 ? 1 : 8;
    @(posedge clk); #1;
    sel1 = w1;
    if (w1) begin a1 = a[0]; b1 = b[0]; bin1 = bi; start1 = 1'b1; end
    else begin a8 = a; b8 = b; bin8 = bi; start8 = 1'b1; end
    push_exp(w1, a, b, bi);
    @(posedge clk); #1;
    start1 = 1'b0;
    start8 = 1'b0;
    lat    = 0;
    busy_n = 0;
    while (!obs_done && lat < 40) begin
      if (obs_busy) busy_n++;
      if (poke != 0 && lat == poke) begin
        a8 = ~a; b8 = ~b; bin8 = ~bi; start8 = 1'b1;
      end else begin
        start8 = 1'b0;
      end
      @(posedge clk); #1;
      lat++;
    end
    start8 = 1'b0;
    chk({tag, " latency"}, 32'(lat), 32'(w));
    chk({tag, " busy cycles"}, 32'(busy_n), 32'(w));
    chk({tag, " busy with done"}, 32'(obs_busy), 32'(0));
    chk({tag, " diff"}, 32'(obs_diff), 32'(qd.pop_front()));
    chk({tag, " bout"}, 32'(obs_bout), 32'(qb.pop_front()));
    @(posedge clk); #1;
    chk({tag, " done pulse width"}, 32'(obs_done), 32'(0));
  endtask

  initial begin
    logic [7:0] ba[4];
    logic [7:0] bb[4];
    logic       bbi[4];
    logic [7:0] held;
    logic       stable, have;
    int         cyc, last_done, n_done;

    rst = 1'b0; start8 = 1'b0; start1 = 1'b0; sel1 = 1'b0;
    a8 = '0; b8 = '0; bin8 = 1'b0; a1 = '0; b1 = '0; bin1 = 1'b0;

    // Asynchronous reset with no clock edge.
    #3 rst = 1'b1;
    #1;
    chk("rst busy8", 32'(busy8), 32'(0));
    chk("rst done8", 32'(done8), 32'(0));
    chk("rst diff8", 32'(diff8), 32'(0));
    chk("rst bout8", 32'(bout8), 32'(0));
    chk("rst busy1", 32'(busy1), 32'(0));
    chk("rst diff1", 32'(diff1), 32'(0));
    @(negedge clk) rst = 1'b0;

    run_op(1'b0, 8'h5A, 8'h23, 1'b0, 0, "5a-23");
    run_op(1'b0, 8'h00, 8'h01, 1'b0, 0, "00-01");
    run_op(1'b0, 8'h10, 8'h10, 1'b1, 0, "10-10-1");
    run_op(1'b0, 8'h80, 8'h7F, 1'b1, 0, "80-7f-1");
    run_op(1'b0, 8'hC3, 8'h3C, 1'b1, 0, "c3-3c-1");

    // start pulsed mid-run must be ignored
    run_op(1'b0, 8'h9C, 8'h41, 1'b1, 3, "start ignored");

    // Reset in the middle of RUN discards the operation
    @(posedge clk); #1;
    sel1 = 1'b0; a8 = 8'hF0; b8 = 8'h0F; bin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (4) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrun rst busy", 32'(busy8), 32'(0));
    chk("midrun rst done", 32'(done8), 32'(0));
    chk("midrun rst diff", 32'(diff8), 32'(0));
    chk("midrun rst bout", 32'(bout8), 32'(0));
    @(negedge clk) rst = 1'b0;
    run_op(1'b0, 8'h47, 8'hB2, 1'b0, 0, "after rst");

    // start held high: one result every WIDTH+2 cycles, diff steady in between
    ba = '{8'h12, 8'hFF, 8'h01, 8'h77};
    bb = '{8'h34, 8'h01, 8'h01, 8'h77};
    bbi = '{1'b0, 1'b1, 1'b1, 1'b0};
    @(posedge clk); #1;
    sel1 = 1'b0;
    a8 = ba[0]; b8 = bb[0]; bin8 = bbi[0]; start8 = 1'b1;
    push_exp(1'b0, ba[0], bb[0], bbi[0]);
    cyc = 0; last_done = 0; n_done = 0; stable = 1'b1; have = 1'b0; held = '0;
    while (n_done < 4 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
      if (done8) begin
        chk("b2b diff", 32'(diff8), 32'(qd.pop_front()));
        chk("b2b bout", 32'(bout8), 32'(qb.pop_front()));
        if (have) begin
          chk("b2b period", 32'(cyc - last_done), 32'(10));
          chk("b2b diff stable", 32'(stable), 32'(1));
        end else begin
          chk("b2b first latency", 32'(cyc), 32'(9));
        end
        last_done = cyc; held = diff8; have = 1'b1; stable = 1'b1;
        n_done++;
        if (n_done < 4) begin
          a8 = ba[n_done]; b8 = bb[n_done]; bin8 = bbi[n_done];
          push_exp(1'b0, ba[n_done], bb[n_done], bbi[n_done]);
        end else begin
          start8 = 1'b0;
        end
      end else if (have && diff8 !== held) begin
        stable = 1'b0;
      end
    end
    start8 = 1'b0;
    chk("b2b completions", 32'(n_done), 32'(4));
    repeat (3) @(posedge clk);

    // WIDTH=1: full-subtractor truth table
    for (int i = 0; i < 8; i++) begin
      run_op(1'b1, {7'b0, i[2]}, {7'b0, i[1]}, i[0], 0, "w1");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
